// File: rtl/arid_pkg.sv
// ============================================================================
// Module      : arid_pkg
// Description : Shared state encoding, constants and wrapping sequence
//               increment for the ARID sequence issuer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package arid_pkg;

    typedef enum logic {
        AR_IDLE = 1'b0,
        AR_HOLD = 1'b1
    } ar_state_e;

    localparam int ID_WIDTH_DEF  = 2;
    localparam int SEQ_WIDTH_DEF = 4;
    localparam int ARID_W        = ID_WIDTH_DEF + SEQ_WIDTH_DEF;

    // Increment modulo 2**width; callers truncate the result to their width.
    function automatic logic [31:0] seq_inc(input logic [31:0] seq, input int width);
        logic [31:0] mask;
        mask = (32'd1 << width) - 32'd1;
        return (seq + 32'd1) & mask;
    endfunction

endpackage

`default_nettype wire

// File: rtl/arid_cpl_tracker.sv
// ============================================================================
// Module      : arid_cpl_tracker
// Description : Detects R-channel burst completions for one ID lane, keeps
//               the outstanding-burst count, expected sequence and the
//               sticky seq_err flag. Optional macro: SEQ_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module arid_cpl_tracker
    import arid_pkg::*;
#(
    parameter int                  ID_WIDTH  = ID_WIDTH_DEF,
    parameter int                  SEQ_WIDTH = SEQ_WIDTH_DEF,
    parameter logic [ID_WIDTH-1:0] ID        = '0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          accept,
    input  logic                          RVALID,
    input  logic                          RREADY,
    input  logic                          RLAST,
    input  logic [ID_WIDTH+SEQ_WIDTH-1:0] RID,
    output logic [SEQ_WIDTH:0]            outstanding,
    output logic                          seq_err
);

    logic [SEQ_WIDTH:0]   r_outstanding;
    logic [SEQ_WIDTH-1:0] r_exp_seq;
    logic                 r_seq_err;
    logic                 w_cpl;
    logic                 w_cpl_ok;
    logic                 w_cpl_orphan;
    logic                 w_seq_mismatch;

    assign w_cpl        = RVALID && RREADY && RLAST && (RID[ID_WIDTH-1:0] == ID);
    assign w_cpl_ok     = w_cpl && (r_outstanding != '0);
    assign w_cpl_orphan = w_cpl && (r_outstanding == '0);

`ifdef SEQ_CHECK_EN
    assign w_seq_mismatch = w_cpl_ok && (RID[ID_WIDTH +: SEQ_WIDTH] != r_exp_seq);
`else
    logic w_unused_rid_seq;
    assign w_unused_rid_seq = ^RID[ID_WIDTH +: SEQ_WIDTH];
    assign w_seq_mismatch   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_outstanding <= '0;
            r_exp_seq     <= '0;
            r_seq_err     <= 1'b0;
        end else begin
            if (accept && !w_cpl_ok) begin
                r_outstanding <= r_outstanding + 1'b1;
            end else if (!accept && w_cpl_ok) begin
                r_outstanding <= r_outstanding - 1'b1;
            end
            if (w_cpl_ok) begin
                r_exp_seq <= SEQ_WIDTH'(seq_inc(32'(r_exp_seq), SEQ_WIDTH));
            end
            if (w_cpl_orphan || w_seq_mismatch) begin
                r_seq_err <= 1'b1;
            end
        end
    end

    assign outstanding = r_outstanding;
    assign seq_err     = r_seq_err;

endmodule

`default_nettype wire

// File: rtl/arid_seq_issuer.sv
// ============================================================================
// Module      : arid_seq_issuer
// Description : Read-address issuer for one ID lane. Tags AR bursts with
//               ARID = {seq, ID} and limits bursts in flight to MAX_OUT.
//               Optional macro: SEQ_CHECK_EN (RID sequence checking).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module arid_seq_issuer
    import arid_pkg::*;
#(
    parameter int                  ID_WIDTH  = ID_WIDTH_DEF,
    parameter int                  SEQ_WIDTH = SEQ_WIDTH_DEF,
    parameter logic [ID_WIDTH-1:0] ID        = '0,
    parameter int                  ADDR_W    = 32,
    parameter int                  MAX_OUT   = 2 ** SEQ_WIDTH
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          req_valid,
    input  logic [ADDR_W-1:0]             req_addr,
    input  logic [7:0]                    req_len,
    output logic                          req_ready,
    output logic                          ARVALID,
    input  logic                          ARREADY,
    output logic [ADDR_W-1:0]             ARADDR,
    output logic [7:0]                    ARLEN,
    output logic [ID_WIDTH+SEQ_WIDTH-1:0] ARID,
    input  logic                          RVALID,
    input  logic                          RREADY,
    input  logic                          RLAST,
    input  logic [ID_WIDTH+SEQ_WIDTH-1:0] RID,
    output logic [SEQ_WIDTH:0]            outstanding,
    output logic                          idle,
    output logic                          seq_err
);

    localparam logic [SEQ_WIDTH:0] C_MAX_OUT = (SEQ_WIDTH + 1)'(MAX_OUT);

    ar_state_e                     r_state;
    ar_state_e                     w_state_nxt;
    logic [ADDR_W-1:0]             r_araddr;
    logic [7:0]                    r_arlen;
    logic [ID_WIDTH+SEQ_WIDTH-1:0] r_arid;
    logic [SEQ_WIDTH-1:0]          r_next_seq;
    logic                          w_accept;
    logic                          w_req_ready;
    logic [SEQ_WIDTH:0]            w_outstanding;

    // A completion in this cycle is deliberately not credited until next cycle.
    assign w_req_ready = ((r_state == AR_IDLE) || ARREADY) && (w_outstanding != C_MAX_OUT);
    assign w_accept    = req_valid && w_req_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= AR_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            AR_IDLE: if (w_accept) w_state_nxt = AR_HOLD;
            AR_HOLD: if (ARREADY && !w_accept) w_state_nxt = AR_IDLE;
            default: w_state_nxt = AR_IDLE;
        endcase
    end

    // Payload only loads on accept, which keeps it stable while the beat is stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_araddr   <= '0;
            r_arlen    <= '0;
            r_arid     <= '0;
            r_next_seq <= '0;
        end else if (w_accept) begin
            r_araddr   <= req_addr;
            r_arlen    <= req_len;
            r_arid     <= {r_next_seq, ID};
            r_next_seq <= SEQ_WIDTH'(seq_inc(32'(r_next_seq), SEQ_WIDTH));
        end
    end

    arid_cpl_tracker #(
        .ID_WIDTH  (ID_WIDTH),
        .SEQ_WIDTH (SEQ_WIDTH),
        .ID        (ID)
    ) u_cpl_tracker (
        .clk         (clk),
        .reset       (reset),
        .accept      (w_accept),
        .RVALID      (RVALID),
        .RREADY      (RREADY),
        .RLAST       (RLAST),
        .RID         (RID),
        .outstanding (w_outstanding),
        .seq_err     (seq_err)
    );

    assign req_ready   = w_req_ready;
    assign ARVALID     = (r_state == AR_HOLD);
    assign ARADDR      = r_araddr;
    assign ARLEN       = r_arlen;
    assign ARID        = r_arid;
    assign outstanding = w_outstanding;
    assign idle        = (w_outstanding == '0) && (r_state == AR_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_arid_seq_issuer.sv
// ============================================================================
// Module      : tb_arid_seq_issuer
// Description : Directed self-checking bench for arid_seq_issuer (default
//               parameters, ID = 0). Optional macro: SEQ_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_arid_seq_issuer;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic [31:0] req_addr;
    logic [7:0]  req_len;
    logic        req_ready;
    logic        ARVALID;
    logic        ARREADY;
    logic [31:0] ARADDR;
    logic [7:0]  ARLEN;
    logic [5:0]  ARID;
    logic        RVALID;
    logic        RREADY;
    logic        RLAST;
    logic [5:0]  RID;
    logic [4:0]  outstanding;
    logic        idle;
    logic        seq_err;

    int n_pass  = 0;
    int n_total = 0;

    arid_seq_issuer dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_addr    (req_addr),
        .req_len     (req_len),
        .req_ready   (req_ready),
        .ARVALID     (ARVALID),
        .ARREADY     (ARREADY),
        .ARADDR      (ARADDR),
        .ARLEN       (ARLEN),
        .ARID        (ARID),
        .RVALID      (RVALID),
        .RREADY      (RREADY),
        .RLAST       (RLAST),
        .RID         (RID),
        .outstanding (outstanding),
        .idle        (idle),
        .seq_err     (seq_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 ns after the next rising edge; inputs change and outputs are sampled here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_valid = 1'b0;
        RVALID = 1'b0; RREADY = 1'b0; RLAST = 1'b0; RID = '0;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        ARREADY = 1'b1;
        do_reset();
        n_total++; if ({ARVALID, idle, req_ready, seq_err} !== 4'b0110) $display("FAIL reset_flags: got %b expected 0110", {ARVALID, idle, req_ready, seq_err}); else n_pass++;
        n_total++; if (outstanding !== 5'd0) $display("FAIL reset_outstanding: got %0d expected 0", outstanding); else n_pass++;
        n_total++; if (ARID !== 6'h00 || ARADDR !== 32'h0 || ARLEN !== 8'h0) $display("FAIL reset_payload: got id %h addr %h len %h expected zeros", ARID, ARADDR, ARLEN); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [5:0] exp_id [3];
        exp_id[0] = 6'h00; exp_id[1] = 6'h04; exp_id[2] = 6'h08;
        ARREADY = 1'b1;
        req_valid = 1'b1; req_addr = 32'h1000; req_len = 8'd3;
        for (int i = 0; i < 3; i++) begin
            tick();
            req_addr = 32'h1000 + 32'(i + 1) * 32'h40;
            if (i == 2) req_valid = 1'b0;
            n_total++; if (ARVALID !== 1'b1 || ARID !== exp_id[i]) $display("FAIL b2b_arid%0d: got v=%b id=%h expected v=1 id=%h", i, ARVALID, ARID, exp_id[i]); else n_pass++;
            n_total++; if (ARADDR !== 32'h1000 + 32'(i) * 32'h40) $display("FAIL b2b_araddr%0d: got %h expected %h", i, ARADDR, 32'h1000 + 32'(i) * 32'h40); else n_pass++;
        end
        n_total++; if (outstanding !== 5'd3) $display("FAIL b2b_outstanding: got %0d expected 3", outstanding); else n_pass++;
        tick();
        n_total++; if (ARVALID !== 1'b0) $display("FAIL b2b_drain: got ARVALID %b expected 0", ARVALID); else n_pass++;
    endtask

    task automatic test_stall();
        int bad;
        bad = 0;
        ARREADY = 1'b0;
        req_valid = 1'b1; req_addr = 32'hB000; req_len = 8'd7;
        tick();
        req_addr = 32'hC000; req_len = 8'd1;
        for (int i = 0; i < 5; i++) begin
            if (ARVALID !== 1'b1 || ARADDR !== 32'hB000 || ARLEN !== 8'd7 || ARID !== 6'h0C || req_ready !== 1'b0) bad++;
            tick();
        end
        n_total++; if (bad !== 0) $display("FAIL stall_stable: got %0d unstable cycles expected 0", bad); else n_pass++;
        ARREADY = 1'b1;
        #1;
        n_total++; if (req_ready !== 1'b1) $display("FAIL stall_ready: got %b expected 1", req_ready); else n_pass++;
        tick();
        req_valid = 1'b0;
        n_total++; if (ARVALID !== 1'b1 || ARADDR !== 32'hC000 || ARID !== 6'h10) $display("FAIL stall_next: got v=%b addr=%h id=%h expected v=1 addr=0000c000 id=10", ARVALID, ARADDR, ARID); else n_pass++;
        tick();
        n_total++; if (outstanding !== 5'd5 || ARVALID !== 1'b0) $display("FAIL stall_out: got out=%0d v=%b expected out=5 v=0", outstanding, ARVALID); else n_pass++;
    endtask

    task automatic test_same_cycle_and_foreign_id();
        ARREADY = 1'b0;
        req_valid = 1'b1; req_addr = 32'hD000; req_len = 8'd0;
        RVALID = 1'b1; RREADY = 1'b1; RLAST = 1'b1; RID = 6'h00;
        tick();
        req_valid = 1'b0;
        RID = 6'h01;
        n_total++; if (outstanding !== 5'd5 || ARID !== 6'h14) $display("FAIL same_cycle: got out=%0d id=%h expected out=5 id=14", outstanding, ARID); else n_pass++;
        tick();
        RVALID = 1'b0; RREADY = 1'b0; RLAST = 1'b0; RID = '0;
        n_total++; if (outstanding !== 5'd5 || seq_err !== 1'b0) $display("FAIL foreign_id: got out=%0d err=%b expected out=5 err=0", outstanding, seq_err); else n_pass++;
    endtask

    task automatic test_reset_midflight();
        n_total++; if (ARVALID !== 1'b1 || outstanding !== 5'd5) $display("FAIL midflight_pre: got v=%b out=%0d expected v=1 out=5", ARVALID, outstanding); else n_pass++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        ARREADY = 1'b1;
        n_total++; if (ARVALID !== 1'b0 || outstanding !== 5'd0 || idle !== 1'b1) $display("FAIL midflight_reset: got v=%b out=%0d idle=%b expected v=0 out=0 idle=1", ARVALID, outstanding, idle); else n_pass++;
        req_valid = 1'b1; req_addr = 32'hE000;
        tick();
        req_valid = 1'b0;
        n_total++; if (ARVALID !== 1'b1 || ARID !== 6'h00) $display("FAIL midflight_seq: got v=%b id=%h expected v=1 id=00", ARVALID, ARID); else n_pass++;
        tick();
    endtask

    task automatic test_full_and_wrap();
        ARREADY = 1'b1;
        do_reset();
        req_valid = 1'b1; req_addr = 32'hF000; req_len = 8'd15;
        for (int i = 0; i < 16; i++) tick();
        n_total++; if (outstanding !== 5'd16 || ARID !== 6'h3C) $display("FAIL full_count: got out=%0d id=%h expected out=16 id=3c", outstanding, ARID); else n_pass++;
        n_total++; if (req_ready !== 1'b0) $display("FAIL full_ready: got %b expected 0", req_ready); else n_pass++;
        tick();
        n_total++; if (ARVALID !== 1'b0 || outstanding !== 5'd16) $display("FAIL full_hold: got v=%b out=%0d expected v=0 out=16", ARVALID, outstanding); else n_pass++;
        RVALID = 1'b1; RREADY = 1'b1; RLAST = 1'b1; RID = 6'h00;
        #1;
        n_total++; if (req_ready !== 1'b0) $display("FAIL full_cpl_same: got %b expected 0", req_ready); else n_pass++;
        tick();
        RVALID = 1'b0; RREADY = 1'b0; RLAST = 1'b0;
        n_total++; if (req_ready !== 1'b1 || outstanding !== 5'd15) $display("FAIL full_freed: got rdy=%b out=%0d expected rdy=1 out=15", req_ready, outstanding); else n_pass++;
        tick();
        req_valid = 1'b0;
        n_total++; if (ARVALID !== 1'b1 || ARID !== 6'h00 || outstanding !== 5'd16) $display("FAIL wrap_arid: got v=%b id=%h out=%0d expected v=1 id=00 out=16", ARVALID, ARID, outstanding); else n_pass++;
        tick();
    endtask

    task automatic test_seq_err();
        ARREADY = 1'b1;
        do_reset();
        RVALID = 1'b1; RREADY = 1'b1; RLAST = 1'b1; RID = 6'h00;
        tick();
        RVALID = 1'b0; RREADY = 1'b0; RLAST = 1'b0;
        n_total++; if (seq_err !== 1'b1 || outstanding !== 5'd0) $display("FAIL orphan_err: got err=%b out=%0d expected err=1 out=0", seq_err, outstanding); else n_pass++;
        tick(); tick();
        n_total++; if (seq_err !== 1'b1) $display("FAIL orphan_sticky: got %b expected 1", seq_err); else n_pass++;
`ifdef SEQ_CHECK_EN
        do_reset();
        req_valid = 1'b1; req_addr = 32'hA000;
        tick();
        req_valid = 1'b0;
        RVALID = 1'b1; RREADY = 1'b1; RLAST = 1'b1; RID = 6'h04;
        tick();
        RVALID = 1'b0; RREADY = 1'b0; RLAST = 1'b0; RID = '0;
        n_total++; if (seq_err !== 1'b1 || outstanding !== 5'd0) $display("FAIL seq_mismatch: got err=%b out=%0d expected err=1 out=0", seq_err, outstanding); else n_pass++;
        tick(); tick();
        n_total++; if (seq_err !== 1'b1) $display("FAIL seq_mismatch_sticky: got %b expected 1", seq_err); else n_pass++;
`endif
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_addr = '0; req_len = '0; ARREADY = 1'b1;
        RVALID = 1'b0; RREADY = 1'b0; RLAST = 1'b0; RID = '0;
        test_reset();
        test_back_to_back();
        test_stall();
        test_same_cycle_and_foreign_id();
        test_reset_midflight();
        test_full_and_wrap();
        test_seq_err();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
